// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared encodings, FSM state type and the alignment check for
//                the load/store unit in front of the data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access size encodings carried on ReqSize
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // The unused size code 2'b11 is reported as misaligned so that it never
    // reaches memory.
    function automatic logic isMisaligned(input logic [1:0] size,
                                          input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            SZ_WORD: bad = |addrLo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Pipeline request/response handshake plus the word-wide data
//                memory port, as seen by the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

    // Pipeline request
    logic        Req;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWrData;

    // Pipeline response
    logic        Ready;
    logic        Done;
    logic [31:0] RdData;
    logic        AlignErr;
    logic        RangeErr;

    // Data memory port
    logic [31:0] DmemAddr;
    logic        DmemWrite;
    logic [31:0] DmemWrData;
    logic [31:0] DmemRdData;

    // Pipeline and memory side
    modport master (
        output Req, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData,
        input  Ready, Done, RdData, AlignErr, RangeErr,
        input  DmemAddr, DmemWrite, DmemWrData,
        output DmemRdData
    );

    // Load/store unit side
    modport slave (
        input  Req, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData,
        output Ready, Done, RdData, AlignErr, RangeErr,
        output DmemAddr, DmemWrite, DmemWrData,
        input  DmemRdData
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-lane steering. Extracts and extends a
//                load lane from a memory word, and merges sub-word store data
//                into an old memory word. Lanes are little-endian.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import mem_access_pkg::*;
(
    input  wire logic [31:0] LoadWord,
    input  wire logic [1:0]  AddrLo,
    input  wire logic [1:0]  Size,
    input  wire logic        IsSigned,
    output logic      [31:0] LoadResult,
    input  wire logic [31:0] OldWord,
    input  wire logic [31:0] NewData,
    output logic      [31:0] MergedWord
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane and sign- or zero-extend it to 32 bits
    always_comb begin
        w_byte     = LoadWord[{AddrLo, 3'b000} +: 8];
        w_half     = AddrLo[1] ? LoadWord[31:16] : LoadWord[15:0];
        LoadResult = LoadWord;
        case (Size)
            SZ_BYTE: LoadResult = {{24{IsSigned & w_byte[7]}}, w_byte};
            SZ_HALF: LoadResult = {{16{IsSigned & w_half[15]}}, w_half};
            default: LoadResult = LoadWord;
        endcase
    end

    // Replace only the target lane of the old word with the low store bits
    always_comb begin
        MergedWord = OldWord;
        case (Size)
            SZ_BYTE: MergedWord[{AddrLo, 3'b000} +: 8] = NewData[7:0];
            SZ_HALF: MergedWord[{AddrLo[1], 4'b0000} +: 16] = NewData[15:0];
            default: MergedWord = NewData;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : CPU load/store unit driving a word-only data memory. Handles
//                byte/half/word loads with extension, and sub-word stores via
//                read-modify-write. Req/Ready/Done handshake to the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  wire logic        Clk,
    input  wire logic        Rst_n,
    mem_access_unit_if.slave Bus
);

    localparam logic [31:0] c_memLimit = 32'(MEM_BYTES);

    state_t      r_state;
    state_t      w_nextState;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wrData;
    logic [31:0] r_memWord;
    logic [31:0] r_rdData;
    logic        r_alignErr;
    logic        r_rangeErr;

    logic        w_accept;
    logic        w_alignBad;
    logic        w_rangeBad;
    logic [31:0] w_loadResult;
    logic [31:0] w_mergedWord;

    assign w_accept   = Bus.Req && (r_state == IDLE);
    assign w_alignBad = isMisaligned(Bus.ReqSize, Bus.ReqAddr[1:0]);
    // Alignment has priority: a misaligned access reports only AlignErr
    assign w_rangeBad = !w_alignBad && (Bus.ReqAddr >= c_memLimit);

    lsu_lane_align u_laneAlign (
        .LoadWord   (Bus.DmemRdData),
        .AddrLo     (r_addr[1:0]),
        .Size       (r_size),
        .IsSigned   (r_signed),
        .LoadResult (w_loadResult),
        .OldWord    (Bus.DmemRdData),
        .NewData    (r_wrData),
        .MergedWord (w_mergedWord)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; the path is chosen once, at accept
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_alignBad || w_rangeBad) begin
                        w_nextState = RESP;
                    end else if (!Bus.ReqWrite) begin
                        w_nextState = LOAD;
                    end else if (Bus.ReqSize == SZ_WORD) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = RMW_RD;
                    end
                end
            end
            LOAD:    w_nextState = RESP;
            RMW_RD:  w_nextState = WRITE;
            WRITE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Capture the request fields on accept
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_write  <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wrData <= '0;
        end else if (w_accept) begin
            r_write  <= Bus.ReqWrite;
            r_size   <= Bus.ReqSize;
            r_signed <= Bus.ReqSigned;
            r_addr   <= Bus.ReqAddr;
            r_wrData <= Bus.ReqWrData;
        end
    end

    // Word to be written: raw store data for a word store, merged word for RMW
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_memWord <= '0;
        end else if (w_accept) begin
            r_memWord <= Bus.ReqWrData;
        end else if (r_state == RMW_RD) begin
            r_memWord <= w_mergedWord;
        end
    end

    // Load result register; stores leave it untouched
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rdData <= '0;
        end else if (r_state == LOAD) begin
            r_rdData <= w_loadResult;
        end
    end

    // Error flags change only on the edge that enters RESP
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_alignErr <= 1'b0;
            r_rangeErr <= 1'b0;
        end else if (w_accept && (w_alignBad || w_rangeBad)) begin
            r_alignErr <= w_alignBad;
            r_rangeErr <= w_rangeBad;
        end else if ((r_state == LOAD) || (r_state == WRITE)) begin
            r_alignErr <= 1'b0;
            r_rangeErr <= 1'b0;
        end
    end

    // Outputs decoded purely from registered state
    assign Bus.Ready      = (r_state == IDLE);
    assign Bus.Done       = (r_state == RESP);
    assign Bus.RdData     = r_rdData;
    assign Bus.AlignErr   = r_alignErr;
    assign Bus.RangeErr   = r_rangeErr;
    assign Bus.DmemAddr   = ((r_state == LOAD) || (r_state == RMW_RD) || (r_state == WRITE))
                            ? {r_addr[31:2], 2'b00} : 32'h0;
    assign Bus.DmemWrite  = (r_state == WRITE) && r_write;
    assign Bus.DmemWrData = (r_state == WRITE) ? r_memWord : 32'h0;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: the CPU load/store unit that drives DmemAddr, DmemWrite and DmemWrData, and consumes DmemRdData.
- Sits between the MEM stage and the word-only data memory.
- Provides byte, halfword and word loads and stores, with sign or zero extension.
- Sub-word stores are done by read-modify-write, because the memory writes only whole words.
- Uses a simple Req/Ready/Done handshake toward the pipeline.

Parameters:
- MEM_BYTES, 1024: addressable bytes. Any access at or above this address is a range error.

Ports:
- Clk  in  1  clock; all logic on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Req  in  1  request valid; accepted when Req && Ready.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as an align error).
- ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- ReqAddr  in  32  byte address.
- ReqWrData  in  32  store data; low bits are used for sub-word stores.
- Ready  out  1  high only in IDLE.
- Done  out  1  one-cycle completion pulse.
- RdData  out  32  registered load result; valid while Done=1 and held until the next load completes.
- AlignErr  out  1  valid with Done; misaligned address or ReqSize=11.
- RangeErr  out  1  valid with Done; ReqAddr >= MEM_BYTES.
- DmemAddr  out  32  word-aligned address {addr[31:2],2'b00}; 0 when no access is in progress.
- DmemWrite  out  1  memory write strobe.
- DmemWrData  out  32  memory write data.
- DmemRdData  in  32  combinational memory read data; valid in the same cycle while DmemWrite=0.

Behaviour:
- Reset values: Ready=1, Done=0, RdData=0, AlignErr=0, RangeErr=0, DmemAddr=0, DmemWrite=0, DmemWrData=0. State is IDLE.
- On accept, latch ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqWrData. Req while Ready=0 is ignored; nothing is queued.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, and so on up to 3 for bits 31:24. Halfword at addr[1]=0 is bits 15:0, at addr[1]=1 bits 31:16.
- Alignment: a half needs addr[0]=0; a word needs addr[1:0]=0.
- States:
  - IDLE: Ready=1. On accept:
    - error -> RESP (align is checked before range);
    - load -> LOAD;
    - word store -> WRITE;
    - sub-word store -> RMW_RD.
  - LOAD: drive DmemAddr with DmemWrite=0. At the posedge, RdData <= extracted and extended lane -> RESP.
  - RMW_RD: drive DmemAddr with DmemWrite=0. At the posedge, capture DmemRdData into the merge register -> WRITE.
  - WRITE: DmemWrite=1 for exactly one cycle. DmemAddr is held. DmemWrData is ReqWrData for a word store, or the captured word with the target lane replaced -> RESP.
  - RESP: Done=1; AlignErr and RangeErr show their latched values -> IDLE.
- Latency from the accept edge to Done=1:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- An error never touches memory: DmemAddr stays 0 and DmemWrite stays 0.
- DmemWrite, DmemAddr and DmemWrData are decoded from registered state only and are glitch-free.
- Error flags and RdData are cleared or updated only when the next transaction reaches RESP. A store does not change RdData.
- The next Req can be accepted in the cycle after Done (IDLE). There is no accept in RESP.
- Reset mid-operation: all outputs return to their reset values asynchronously. A pending WRITE is abandoned and memory is unchanged. There is no Done pulse for the abandoned transaction.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum IDLE, LOAD, RMW_RD, WRITE, RESP;
  - the align-check function.
- Sub-module lsu_lane_align is combinational. It performs load extract/extend, giving (word, addr[1:0], size, signed) -> 32-bit result. It also performs store merge, giving (old word, new data, addr[1:0], size) -> 32-bit word.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Memory model word at 0x10 = 0x8899AABB.
- LW 0x10 -> Done exactly 2 cycles after the accept edge, RdData=0x8899AABB, DmemWrite never high, errors 0.
- LB signed 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH signed 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
- SB 0x13 with data 0x12345655 -> RMW_RD reads 0x8899AABB, a single DmemWrite pulse writes 0x5599AABB to 0x10, Done at 3 cycles. A following LW 0x10 returns 0x5599AABB.
- SW 0x14 with 0xDEADBEEF -> one write cycle, Done at 2 cycles. SH 0x11 -> AlignErr=1, Done at 1 cycle, no DmemWrite, memory unchanged. LW 0x400 with MEM_BYTES=1024 -> RangeErr=1.
- Req held high during a busy transaction and back-to-back requests -> only accepted when Ready=1, and each transaction produces exactly one Done.
- Rst_n low during RMW_RD of an SB -> DmemWrite never asserts, memory unchanged, Ready=1 and all other outputs 0 immediately.
